// File: rtl/spi_alu_frame_unit.sv
// rtl/spi_alu_frame_unit.sv - SPI-slave ALU: load A, B, opcode per CS-low frame, return {result, flags}
//
// Purpose: serial arithmetic unit. Each chip-select-low window shifts in
//   A (M bits), B (M bits) and an opcode (N bits), MSB first. It then
//   computes and commits the result and flags, and shifts {result, flags}
//   back out on MISO in the same frame.
// Ports:
//   i_sclk       SPI clock, all logic on posedge
//   i_rst        async active-low reset
//   i_cs         chip select, active low
//   i_mosi       serial data in, MSB first
//   o_miso       serial data out, registered, MSB first
//   o_done       one-cycle pulse after a result commit
//   o_frame_err  sticky abort indicator, cleared at next frame start
//   o_result     last committed result
//   o_flags      last committed flags {BF,ZF,OF,SF}
module spi_alu_frame_unit #(
  parameter int M     = 8,
  parameter int N     = 4,
  parameter int FLAGS = 4
) (
  input  logic             i_sclk,
  input  logic             i_rst,
  input  logic             i_cs,
  input  logic             i_mosi,
  output logic             o_miso,
  output logic             o_done,
  output logic             o_frame_err,
  output logic [M-1:0]     o_result,
  output logic [FLAGS-1:0] o_flags
);

  localparam int FW = M + FLAGS;
  localparam int SW = $clog2(M);
  localparam int CW = $clog2(M + N + FLAGS) + 1;

  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] M_LAST    = CW'(M - 1);
  localparam logic [CW-1:0] N_LAST    = CW'(N - 1);
  localparam logic [CW-1:0] SEND_LAST = CW'(FW - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_LOAD_OP, S_EXEC, S_SEND, S_WAIT
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [M-1:0]     a_q, a_d, b_q, b_d, res_q, res_d;
  logic [N-1:0]     op_q, op_d;
  logic [FW-1:0]    sh_q, sh_d;
  logic [FLAGS-1:0] flg_q, flg_d;
  logic             miso_q, miso_d, done_q, done_d, err_q, err_d;

  logic [M-1:0]     alu_res;
  logic             alu_of, alu_bf;
  logic [FLAGS-1:0] alu_flags;
  logic [FW-1:0]    alu_frame;
  logic [SW-1:0]    shamt;

  // Opcodes 0..7 are defined; anything at or above 8 is flagged invalid.
  always_comb begin
    alu_res = '0;
    alu_of  = 1'b0;
    alu_bf  = 1'b0;
    shamt   = b_q[SW-1:0];
    case (op_q[2:0])
      3'd0: begin
        alu_res = a_q + b_q;
        alu_of  = (a_q[M-1] == b_q[M-1]) && (alu_res[M-1] != a_q[M-1]);
      end
      3'd1: begin
        alu_res = a_q - b_q;
        alu_of  = (a_q[M-1] != b_q[M-1]) && (alu_res[M-1] != a_q[M-1]);
      end
      3'd2:    alu_res = a_q & b_q;
      3'd3:    alu_res = a_q | b_q;
      3'd4:    alu_res = a_q ^ b_q;
      3'd5:    alu_res = ~a_q;
      3'd6:    alu_res = a_q << shamt;
      default: alu_res = a_q >> shamt;
    endcase
    if (32'(op_q) >= 32'd8) begin
      alu_res = '0;
      alu_of  = 1'b0;
      alu_bf  = 1'b1;
    end
    alu_flags = {alu_bf, ~|alu_res, alu_of, alu_res[M-1]};
    alu_frame = {alu_res, alu_flags};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    sh_d    = sh_q;
    res_d   = res_q;
    flg_d   = flg_q;
    err_d   = err_q;
    miso_d  = 1'b0;
    done_d  = 1'b0;
    // CS high in any active state except WAIT is a mid-frame abort.
    if (i_cs && state_q != S_IDLE && state_q != S_WAIT) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: if (!i_cs) begin
          state_d = S_LOAD_A;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
        S_LOAD_A: begin
          a_d = {a_q[M-2:0], i_mosi};
          if (cnt_q == M_LAST) begin
            cnt_d   = '0;
            state_d = S_LOAD_B;
          end else cnt_d = cnt_q + CNT_ONE;
        end
        S_LOAD_B: begin
          b_d = {b_q[M-2:0], i_mosi};
          if (cnt_q == M_LAST) begin
            cnt_d   = '0;
            state_d = S_LOAD_OP;
          end else cnt_d = cnt_q + CNT_ONE;
        end
        S_LOAD_OP: begin
          op_d = {op_q[N-2:0], i_mosi};
          if (cnt_q == N_LAST) begin
            cnt_d   = '0;
            state_d = S_EXEC;
          end else cnt_d = cnt_q + CNT_ONE;
        end
        // The first output bit goes out on the commit edge, so SEND only
        // has to produce the remaining FW-1 bits plus one trailing edge.
        S_EXEC: begin
          res_d   = alu_res;
          flg_d   = alu_flags;
          done_d  = 1'b1;
          miso_d  = alu_frame[FW-1];
          sh_d    = {alu_frame[FW-2:0], 1'b0};
          cnt_d   = '0;
          state_d = S_SEND;
        end
        S_SEND: begin
          if (cnt_q == SEND_LAST) state_d = S_WAIT;
          else begin
            miso_d = sh_q[FW-1];
            sh_d   = {sh_q[FW-2:0], 1'b0};
            cnt_d  = cnt_q + CNT_ONE;
          end
        end
        S_WAIT:  if (i_cs) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_sclk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      sh_q    <= '0;
      res_q   <= '0;
      flg_q   <= '0;
      err_q   <= 1'b0;
      miso_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      sh_q    <= sh_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
      err_q   <= err_d;
      miso_q  <= miso_d;
      done_q  <= done_d;
    end
  end

  assign o_miso      = miso_q;
  assign o_done      = done_q;
  assign o_frame_err = err_q;
  assign o_result    = res_q;
  assign o_flags     = flg_q;

endmodule

// File: tb/tb_spi_alu_frame_unit.sv
// tb/tb_spi_alu_frame_unit.sv - self-checking bench for spi_alu_frame_unit
module tb_spi_alu_frame_unit;

  localparam int M  = 8;
  localparam int N  = 4;
  localparam int FW = M + 4;
  localparam int E  = 2 * M + N + 2;     // frame posedge index of EXEC
  localparam int L  = E + FW;            // last SEND posedge index

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cs;
  logic         mosi;
  logic         miso, done, ferr;
  logic [M-1:0] result;
  logic [3:0]   flags;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic         exp_miso = 1'b0;
  logic         exp_done = 1'b0;
  logic         exp_err  = 1'b0;
  logic [M-1:0] exp_res  = '0;
  logic [3:0]   exp_flg  = '0;

  spi_alu_frame_unit #(.M(M), .N(N), .FLAGS(4)) dut (
    .i_sclk(clk), .i_rst(rst_n), .i_cs(cs), .i_mosi(mosi),
    .o_miso(miso), .o_done(done), .o_frame_err(ferr),
    .o_result(result), .o_flags(flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference: {result[7:0], BF, ZF, OF, SF} from plain integer arithmetic.
  function automatic logic [11:0] model(input int a, input int b, input int op);
    int sa, sb, s, r;
    logic of, bf;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    of = 1'b0;
    bf = 1'b0;
    r  = 0;
    case (op)
      0: begin s = sa + sb; of = (s > 127 || s < -128); r = s & 255; end
      1: begin s = sa - sb; of = (s > 127 || s < -128); r = s & 255; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (~a) & 255;
      6: r = (a << (b % 8)) & 255;
      7: r = a >> (b % 8);
      default: begin r = 0; bf = 1'b1; end
    endcase
    return {r[7:0], bf, (r == 0), of, r[7]};
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("miso",   {31'd0, miso}, {31'd0, exp_miso});
      chk("done",   {31'd0, done}, {31'd0, exp_done});
      chk("ferr",   {31'd0, ferr}, {31'd0, exp_err});
      chk("result", {24'd0, result}, {24'd0, exp_res});
      chk("flags",  {28'd0, flags}, {28'd0, exp_flg});
    end
  end

  task automatic cyc(input logic c, input logic d, input logic em, input logic ed);
    cs   = c;
    mosi = d;
    @(posedge clk);
    #1;
    exp_miso = em;
    exp_done = ed;
  endtask

  // One frame; posedge 1 is the IDLE edge that sees CS low. abort_at raises
  // CS at that posedge; stop_at returns mid-frame without finishing.
  task automatic run_frame(input int a, input int b, input int op, input int hold,
                           input int abort_at, input int stop_at);
    logic [11:0] fr;
    logic [7:0]  av, bv;
    logic [3:0]  ov;
    logic        d, em;
    fr = model(a, b, op);
    av = a[7:0];
    bv = b[7:0];
    ov = op[3:0];
    for (int p = 1; p <= L; p++) begin
      if (p == abort_at) begin
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        exp_err = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        return;
      end
      d = 1'b0;
      if (p >= 2 && p <= M + 1)               d = av[M - 1 - (p - 2)];
      else if (p >= M + 2 && p <= 2 * M + 1)  d = bv[M - 1 - (p - M - 2)];
      else if (p >= 2 * M + 2 && p <= E - 1)  d = ov[N - 1 - (p - 2 * M - 2)];
      em = (p >= E && p < E + FW) ? fr[FW - 1 - (p - E)] : 1'b0;
      cyc(1'b0, d, em, p == E);
      if (p == 1) exp_err = 1'b0;
      if (p == E) begin
        exp_res = fr[11:4];
        exp_flg = fr[3:0];
      end
      if (p == stop_at) return;
    end
    for (int h = 0; h < hold; h++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    cs    = 1'b1;
    mosi  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    rst_n  = 1'b1;

    // hand-computed values pinning the model
    chk("model_add_of",  {20'd0, model(8'h7F, 8'h01, 0)}, 32'h803);
    chk("model_sub_z",   {20'd0, model(8'h05, 8'h05, 1)}, 32'h004);
    chk("model_sub_of",  {20'd0, model(8'h80, 8'h01, 1)}, 32'h7F2);
    chk("model_bad_op",  {20'd0, model(8'h12, 8'h34, 15)}, 32'h00C);
    chk("model_shl",     {20'd0, model(8'h81, 8'hF9, 6)}, 32'h020);

    cyc(1'b1, 1'b0, 1'b0, 1'b0);

    // 1: ADD overflow
    run_frame(8'h7F, 8'h01, 0, 0, 0, 0);
    chk("t1_result", {24'd0, result}, 32'h80);
    chk("t1_flags",  {28'd0, flags}, 32'h3);
    // 2: SUB zero and SUB overflow
    run_frame(8'h05, 8'h05, 1, 0, 0, 0);
    run_frame(8'h80, 8'h01, 1, 0, 0, 0);
    chk("t2_result", {24'd0, result}, 32'h7F);
    chk("t2_flags",  {28'd0, flags}, 32'h2);
    // 3: invalid opcode, then SHL using low shift bits only
    run_frame(8'h12, 8'h34, 15, 0, 0, 0);
    chk("t3_bad_flags", {28'd0, flags}, 32'hC);
    run_frame(8'h81, 8'hF9, 6, 0, 0, 0);
    chk("t3_result", {24'd0, result}, 32'h02);
    chk("t3_flags",  {28'd0, flags}, 32'h0);
    // remaining ops and an ADD that wraps to zero
    run_frame(8'hF0, 8'h3C, 2, 0, 0, 0);
    run_frame(8'hF0, 8'h0C, 3, 0, 0, 0);
    run_frame(8'hA5, 8'h0F, 4, 0, 0, 0);
    run_frame(8'h3C, 8'h00, 5, 0, 0, 0);
    run_frame(8'h81, 8'h0B, 7, 0, 0, 0);
    run_frame(8'hFF, 8'h01, 0, 0, 0, 0);
    chk("wrap_flags", {28'd0, flags}, 32'h4);

    // 4: abort after 5 bits of B, then next frame clears the error
    run_frame(8'h33, 8'h44, 2, 0, M + 7, 0);
    chk("t4_err",    {31'd0, ferr}, 32'd1);
    chk("t4_result", {24'd0, result}, 32'h00);
    run_frame(8'h10, 8'h22, 0, 0, 0, 0);
    chk("t4_cleared", {31'd0, ferr}, 32'd0);
    // abort during SEND
    run_frame(8'h01, 8'h02, 0, 0, E + 4, 0);

    // 5: reset mid-SEND
    run_frame(8'h7F, 8'h7F, 0, 0, 0, E + 3);
    #2;
    rst_n = 1'b0;
    cs    = 1'b1;
    #1;
    chk("t5_miso",   {31'd0, miso}, 32'd0);
    chk("t5_result", {24'd0, result}, 32'h00);
    chk("t5_flags",  {28'd0, flags}, 32'h0);
    exp_miso = 1'b0;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    exp_res  = '0;
    exp_flg  = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    run_frame(8'h7F, 8'h7F, 0, 0, 0, 0);
    chk("t5_after", {24'd0, result}, 32'hFE);

    // 6: CS held low in WAIT, then back-to-back frames
    run_frame(8'h0F, 8'h01, 6, 3, 0, 0);
    run_frame(8'h40, 8'hC0, 1, 0, 0, 0);
    chk("t6_result", {24'd0, result}, 32'h80);
    chk("t6_flags",  {28'd0, flags}, 32'h3);

    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
